// File: rtl/rv32i_types.sv
// Shared types for the data-memory responder: FSM state encoding and the
// byte-mask legality helper used by the optional alignment check.
// No ports; imported by dmem_responder.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  // Legal access shapes: one byte, an aligned half-word, or the full word.
  function automatic logic dmem_mask_legal(input logic [3:0] mask);
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: dmem_mask_legal = 1'b1;
      default:                   dmem_mask_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-wide storage array: DEPTH_WORDS x 32, per-byte write enable.
// Latency: combinational read, write commits on the rising clk edge.
// Backpressure: none; the owner sequences every access.
// Ports: clk_i, idx_i (word index), we_i (byte enables), wdata_i, rdata_o.
module dmem_sram_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] idx_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  // Contents are deliberately never reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  // Read sees the pre-write word during the commit cycle.
  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one request, answers after LATENCY cycles.
// Latency: dmem_resp pulses LATENCY cycles after capture; one access per LATENCY+1 cycles.
// Backpressure: none; request inputs are ignored while BUSY or RESP.
// Ports: clk, rst_n (async active-low), dmem_addr/rmask/wmask/wdata in,
//        dmem_rdata/dmem_resp out, dmem_err out when DMEM_RESP_ALIGN_CHECK_EN is defined
//        (that macro enables the byte-mask alignment check).
module dmem_responder
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp
`ifdef DMEM_RESP_ALIGN_CHECK_EN
  ,
  output logic        dmem_err
`endif
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_resp_state_t state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             acc_err;
  logic             in_resp;
  logic [3:0]       sram_we;
  logic [31:0]      sram_rdata;

  // Address bits outside the word index are dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmem_addr[31:AW+2], dmem_addr[1:0]};

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  logic [3:0] rmask_q, rmask_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    rmask_d = rmask_q;
`endif
    case (state_q)
      IDLE: begin
        if ((dmem_rmask | dmem_wmask) != 4'b0000) begin
          idx_d   = dmem_addr[AW+1:2];
          wmask_d = dmem_wmask;
          wdata_d = dmem_wdata;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
          rmask_d = dmem_rmask;
`endif
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        // Leave BUSY on the edge where the counter reaches zero.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wmask_q <= 4'd0;
      wdata_q <= 32'd0;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
      rmask_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
      rmask_q <= rmask_d;
`endif
    end
  end

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  assign acc_err = ((wmask_q != 4'd0) && !dmem_mask_legal(wmask_q)) ||
                   ((rmask_q != 4'd0) && !dmem_mask_legal(rmask_q));
  assign dmem_err = in_resp & acc_err;
`else
  assign acc_err = 1'b0;
`endif

  assign in_resp = (state_q == RESP);
  // A flagged access still responds but never touches storage.
  assign sram_we = (in_resp && !acc_err) ? wmask_q : 4'b0000;

  dmem_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk_i   (clk),
    .idx_i   (idx_q),
    .we_i    (sram_we),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

  assign dmem_resp  = in_resp;
  assign dmem_rdata = in_resp ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import rv32i_types::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr2, wd2, rdata2, addr1, wd1, rdata1;
  logic [3:0]  rm2, wm2, rm1, wm1;
  logic        resp2, resp1;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
  logic        err2, err1;
  logic        exp_err_g;
`endif

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .dmem_addr(addr2), .dmem_rmask(rm2),
    .dmem_wmask(wm2), .dmem_wdata(wd2), .dmem_rdata(rdata2), .dmem_resp(resp2)
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    , .dmem_err(err2)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dmem_addr(addr1), .dmem_rmask(rm1),
    .dmem_wmask(wm1), .dmem_wdata(wd1), .dmem_rdata(rdata1), .dmem_resp(resp1)
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    , .dmem_err(err1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One access on the LATENCY=2 instance. Inputs are scrambled after capture
  // to show that only the latched request is used.
  task automatic access2(input string nm, input logic [31:0] a, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd,
                         input logic chk_rd, input logic [31:0] exp_rd);
    int c;
    addr2 = a; rm2 = rm; wm2 = wm; wd2 = wd;
    @(posedge clk); #1;
    addr2 = a ^ 32'h4; rm2 = 4'hF; wm2 = 4'hF; wd2 = $urandom;
    c = 1;
    while (resp2 !== 1'b1 && c < 20) begin
      if (c == 1) chk({nm, "_busy_rdata"}, rdata2, 32'h0);
      @(posedge clk); #1;
      c++;
    end
    chk({nm, "_latency"}, 32'(c), 32'd2);
    if (resp2 === 1'b1 && chk_rd) chk({nm, "_rdata"}, rdata2, exp_rd);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    if (resp2 === 1'b1) chk({nm, "_err"}, {31'b0, err2}, {31'b0, exp_err_g});
`endif
    addr2 = 32'h0; rm2 = 4'h0; wm2 = 4'h0; wd2 = 32'h0;
    @(posedge clk); #1;
    chk({nm, "_resp_one_cycle"}, {31'b0, resp2}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    addr2 = 0; rm2 = 0; wm2 = 0; wd2 = 0;
    addr1 = 0; rm1 = 0; wm1 = 0; wd1 = 0;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    exp_err_g = 1'b0;
`endif

    //            addr            rm     wm     wdata         chk  expected rdata
    vt[0]  = '{32'h0000_0010, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{32'h0000_0010, 4'hF, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[2]  = '{32'h0000_0020, 4'h0, 4'hF, 32'h11223344, 1'b0, 32'h0};
    vt[3]  = '{32'h0000_0023, 4'h0, 4'h8, 32'hAB000000, 1'b0, 32'h0};
    vt[4]  = '{32'h0000_0020, 4'hF, 4'h0, 32'h0,        1'b1, 32'hAB223344};
    vt[5]  = '{32'h0000_0024, 4'h0, 4'hF, 32'h0,        1'b0, 32'h0};
    vt[6]  = '{32'h0000_0024, 4'h0, 4'h3, 32'h1234CAFE, 1'b0, 32'h0};
    vt[7]  = '{32'h0000_0024, 4'hF, 4'h0, 32'h0,        1'b1, 32'h0000CAFE};
    vt[8]  = '{32'h0000_0024, 4'hF, 4'hF, 32'h55667788, 1'b1, 32'h0000CAFE};
    vt[9]  = '{32'h0000_0024, 4'hF, 4'h0, 32'h0,        1'b1, 32'h55667788};
    vt[10] = '{32'h0000_0000, 4'h0, 4'hF, 32'h0,        1'b0, 32'h0};
    vt[11] = '{32'h0000_1000, 4'h0, 4'h1, 32'h00000055, 1'b0, 32'h0};
    vt[12] = '{32'h0000_0000, 4'h1, 4'h0, 32'h0,        1'b1, 32'h00000055};
    vt[13] = '{32'hFFFF_F010, 4'hF, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[14] = '{32'h0000_0022, 4'h0, 4'h4, 32'h00EE0000, 1'b0, 32'h0};
    vt[15] = '{32'h0000_0020, 4'h2, 4'h0, 32'h0,        1'b1, 32'hABEE3344};

    // Reset state, before any clock edge.
    #3;
    chk("rst_resp2",  {31'b0, resp2}, 32'd0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_resp1",  {31'b0, resp1}, 32'd0);
    chk("rst_rdata1", rdata1, 32'h0);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    chk("rst_err2", {31'b0, err2}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      access2($sformatf("vec%0d", i), vt[i].addr, vt[i].rm, vt[i].wm, vt[i].wd,
              vt[i].chk_rd, vt[i].exp_rd);
    end

    // Reset during BUSY of a write: no response, no commit.
    addr2 = 32'h10; rm2 = 4'h0; wm2 = 4'hF; wd2 = 32'h12345678;
    @(posedge clk); #1;
    rst_n = 1'b0;
    addr2 = 0; wm2 = 0; wd2 = 0;
    #1;
    chk("rst_busy_resp",  {31'b0, resp2}, 32'd0);
    chk("rst_busy_rdata", rdata2, 32'h0);
    @(posedge clk); #1;
    chk("rst_busy_resp_held", {31'b0, resp2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access2("after_rst_read", 32'h10, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);

    // Reset asserted during RESP must drop outputs without waiting for a clock.
    addr2 = 32'h20; rm2 = 4'hF;
    @(posedge clk); #1;
    addr2 = 0; rm2 = 0;
    @(posedge clk); #1;
    chk("resp_before_async_rst", {31'b0, resp2}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_resp",  {31'b0, resp2}, 32'd0);
    chk("async_rst_rdata", rdata2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access2("retained_read", 32'h20, 4'hF, 4'h0, 32'h0, 1'b1, 32'hABEE3344);

`ifdef DMEM_RESP_ALIGN_CHECK_EN
    exp_err_g = 1'b1;
    access2("misaligned_w", 32'h20, 4'h0, 4'b0110, 32'hFFFFFFFF, 1'b0, 32'h0);
    exp_err_g = 1'b0;
    access2("misaligned_after", 32'h20, 4'hF, 4'h0, 32'h0, 1'b1, 32'hABEE3344);
`endif

    // LATENCY=1 instance: preload a word, then hold a read request continuously.
    @(negedge clk);
    addr1 = 32'h40; wm1 = 4'hF; wd1 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("l1_write_resp", {31'b0, resp1}, 32'd1);
    wm1 = 4'h0; wd1 = 32'h0;
    rm1 = 4'hF;
    @(posedge clk); #1;
    chk("l1_gap_resp", {31'b0, resp1}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk($sformatf("l1_pulse%0d", i), {31'b0, resp1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (resp1 === 1'b1) chk($sformatf("l1_rdata%0d", i), rdata1, 32'hA5A5A5A5);
      else                chk($sformatf("l1_zero%0d", i), rdata1, 32'h0);
    end
    rm1 = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("l1_quiet", {31'b0, resp1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL expose parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, >= 2).
REQ-002 The module SHALL expose parameter LATENCY, default 2, cycles from request capture to dmem_resp (legal range 1..15).
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The module SHALL have port clk  input  1  rising-edge clock.
REQ-005 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port dmem_addr  input  32  byte address from the memory stage.
REQ-007 The module SHALL have port dmem_rmask  input  4  byte read mask; nonzero means read request.
REQ-008 The module SHALL have port dmem_wmask  input  4  byte write mask; nonzero means write request.
REQ-009 The module SHALL have port dmem_wdata  input  32  write data, byte lanes aligned to the address word.
REQ-010 The module SHALL have port dmem_rdata  output  32  read word, valid only while dmem_resp is high.
REQ-011 The module SHALL have port dmem_resp  output  1  single-cycle completion pulse.
REQ-012 When DMEM_RESP_ALIGN_CHECK_EN is defined, the module SHALL have port dmem_err  output  1  misaligned-access flag, coincident with dmem_resp.

Function
REQ-013 FSM states: IDLE, BUSY, RESP.
REQ-014 In IDLE, a request is (rmask|wmask) != 0; the request is captured on that rising edge: addr, masks, and wdata are latched, counter is loaded with LATENCY-1, and the FSM goes to BUSY, or to RESP if LATENCY = 1.
REQ-015 In BUSY, the counter decrements each cycle; at 0 the FSM goes to RESP.
REQ-016 dmem_resp SHALL be high for exactly one cycle, LATENCY cycles after the capture edge; the FSM returns to IDLE on the next edge.
REQ-017 A request present in the cycle after RESP SHALL be captured as a new request; back-to-back throughput is one access per LATENCY+1 cycles.
REQ-018 Request inputs changing while in BUSY or RESP SHALL be ignored; only latched values are used.
REQ-019 Word index = latched addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4 bytes.
REQ-020 Writes SHALL update only the bytes enabled by wmask, committing on the RESP-cycle edge.
REQ-021 Reads SHALL return the full 32-bit word; rmask does not zero any lanes, and the initiator extracts bytes/halves itself.
REQ-022 When both rmask and wmask are nonzero, dmem_rdata SHALL return the pre-write word and the write SHALL still commit.
REQ-023 Outside the RESP cycle, dmem_rdata SHALL be 32'h0.

Reset
REQ-024 When rst_n is low, the FSM SHALL go to IDLE, the counter to 0, dmem_resp to 0, dmem_rdata to 0, and dmem_err to 0, immediately and asynchronously.
REQ-025 Reset asserted mid-operation SHALL abort the access with no write commit and no response; storage contents are retained and not cleared.

Configuration
REQ-026 Macro DMEM_RESP_ALIGN_CHECK_EN: when defined, an access whose mask is not a legal single byte, an aligned half (4'b0011 or 4'b1100), or 4'b1111 SHALL raise dmem_err with dmem_resp and suppress the write.
REQ-027 When DMEM_RESP_ALIGN_CHECK_EN is undefined, the dmem_err port is absent, masks are applied as given, and there is no other behavioural difference.

Structure
REQ-028 The state enum dmem_resp_state_t (IDLE, BUSY, RESP) SHALL live in rv32i_types.
REQ-029 Storage SHALL be a sub-module dmem_sram_array (DEPTH_WORDS x 32, per-byte write enable, synchronous write, combinational read); dmem_responder holds only the FSM, counter, and latches.

Verification
REQ-030 LATENCY=2; write addr 0x10, wmask 4'b1111, wdata 0xDEADBEEF, then read 0x10 -> dmem_resp 2 cycles after each capture edge, rdata 0xDEADBEEF.
REQ-031 Byte write addr 0x13, wmask 4'b1000, wdata 0xAB000000 over word 0x11223344; read -> 0xAB223344.
REQ-032 LATENCY=1; back-to-back reads held continuously -> dmem_resp pulses every 2 cycles, never two consecutive cycles high.
REQ-033 DEPTH_WORDS=1024; write 0x55 at addr 0x1000, read addr 0x0 -> byte 0 reads 0x55 (wrap-around).
REQ-034 rst_n low during BUSY of a write -> dmem_resp stays 0; a later read of that address returns the old value.
REQ-035 With DMEM_RESP_ALIGN_CHECK_EN defined, wmask 4'b0110 -> dmem_err=1 with dmem_resp, and memory is unchanged.
